mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 129 ++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the synchronous data RAM, waits out load latency,
// extends load data and forwards the result bus to WB with bypass taps.
`timescale 1ns/1ps

module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_valid,
  input  logic         next_allow_in,
  input  logic [153:0] EXE_MEM_bus_r,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_over,
  output logic [117:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic         MEM_wen,
  output logic [31:0]  MEM_wdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    DONE      = 2'd2
  } state_e;

  // Everything below exe_result travels to WB untouched.
  typedef struct packed {
    logic        inst_load;
    logic        inst_store;
    logic        ls_word;
    logic        lb_sign;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [85:0] wb_fields;
  } exe_mem_bus_t;

  exe_mem_bus_t bus;
  state_e       state_q, state_d;
  logic [31:0]  load_data_q, load_data_d;
  logic         capture;
  logic [3:0]   store_wen;
  logic [7:0]   load_byte;
  logic [31:0]  load_ext;
  logic [31:0]  mem_result;

  assign bus = exe_mem_bus_t'(EXE_MEM_bus_r);

  assign store_wen = bus.ls_word ? 4'hF : (4'b0001 << bus.exe_result[1:0]);

  // NOTE: every combinational output gets a default first so no path
  // through the case statement leaves a value unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    MEM_over = 1'b0;
    dm_wen   = 4'h0;
    capture  = 1'b0;
    if (!MEM_valid) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.inst_load) begin
            state_d = LOAD_WAIT;
          end else begin
            MEM_over = 1'b1;
            state_d  = next_allow_in ? IDLE : DONE;
            if (bus.inst_store) dm_wen = store_wen;
          end
        end
        LOAD_WAIT: begin
          capture = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          MEM_over = 1'b1;
          if (next_allow_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Reset dominates any in-flight instruction: no write, no completion.
    if (reset) begin
      MEM_over = 1'b0;
      dm_wen   = 4'h0;
    end
  end

  assign load_data_d = capture ? dm_rdata : load_data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    load_byte = 8'h00;
    unique case (bus.exe_result[1:0])
      2'd0: load_byte = load_data_q[7:0];
      2'd1: load_byte = load_data_q[15:8];
      2'd2: load_byte = load_data_q[23:16];
      2'd3: load_byte = load_data_q[31:24];
      default: load_byte = load_data_q[7:0];
    endcase
  end

  assign load_ext   = bus.ls_word ? load_data_q
                    : {{24{bus.lb_sign & load_byte[7]}}, load_byte};
  assign mem_result = bus.inst_load ? load_ext : bus.exe_result;

  assign dm_addr  = bus.exe_result;
  assign dm_wdata = bus.ls_word ? bus.store_data : {4{bus.store_data[7:0]}};

  assign MEM_WB_bus = {mem_result, bus.wb_fields};

  // Bypass taps: rf_wen sits at bit 37 and rf_wdest at [36:32] of the WB fields.
  assign MEM_wdest = bus.wb_fields[36:32] & {5{MEM_valid}};
  assign MEM_wen   = bus.wb_fields[37] & MEM_valid;
  assign MEM_wdata = mem_result;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: transaction-level model with a byte-array
// memory image predicts every store strobe, load result and completion cycle.
`timescale 1ns/1ps

module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         MEM_valid;
  logic         next_allow_in;
  logic [153:0] EXE_MEM_bus_r;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic [31:0]  dm_rdata;
  logic         MEM_over;
  logic [117:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic         MEM_wen;
  logic [31:0]  MEM_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_mem [0:255];
  logic [31:0] ram     [0:63];

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .MEM_valid     (MEM_valid),
    .next_allow_in (next_allow_in),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .dm_addr       (dm_addr),
    .dm_wen        (dm_wen),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .MEM_wdest     (MEM_wdest),
    .MEM_wen       (MEM_wen),
    .MEM_wdata     (MEM_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous data RAM, reloaded from the expected image while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++)
        ram[i] <= {exp_mem[4*i+3], exp_mem[4*i+2], exp_mem[4*i+1], exp_mem[4*i]};
    end else begin
      for (int b = 0; b < 4; b++)
        if (dm_wen[b]) ram[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
    dm_rdata <= ram[dm_addr[7:2]];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [153:0] make_bus(input logic ld, input logic st, input logic wd,
                                            input logic sg, input logic [31:0] sdata,
                                            input logic [31:0] eres, input logic [85:0] rest);
    return {ld, st, wd, sg, sdata, eres, rest};
  endfunction

  function automatic logic [85:0] rand_rest();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[85:0];
  endfunction

  // kind: 0 alu, 1 sw, 2 sb, 3 lw, 4 lb. stall = extra cycles WB holds off.
  task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic sgn, input int stall, input logic [85:0] rest);
    logic        ld, st, wd;
    logic [31:0] res, wdata;
    logic [3:0]  wen;
    logic [7:0]  a, bt;
    int          first, total;
    ld = (kind >= 3);
    st = (kind == 1) || (kind == 2);
    wd = (kind == 1) || (kind == 3);
    a  = addr[7:0];
    res = addr; wen = 4'h0; wdata = 32'h0;
    case (kind)
      1: begin
        wen = 4'hF; wdata = sdata;
        for (int b = 0; b < 4; b++) exp_mem[{a[7:2], 2'(b)}] = sdata[8*b +: 8];
      end
      2: begin
        wen = 4'b0001 << a[1:0]; wdata = {4{sdata[7:0]}};
        exp_mem[a] = sdata[7:0];
      end
      3: res = {exp_mem[{a[7:2], 2'd3}], exp_mem[{a[7:2], 2'd2}],
                exp_mem[{a[7:2], 2'd1}], exp_mem[{a[7:2], 2'd0}]};
      4: begin
        bt  = exp_mem[a];
        res = sgn ? {{24{bt[7]}}, bt} : {24'h0, bt};
      end
      default: ;
    endcase
    first = ld ? 2 : 0;
    total = first + 1 + stall;
    EXE_MEM_bus_r = make_bus(ld, st, wd, sgn, sdata, addr, rest);
    MEM_valid     = 1'b1;
    for (int c = 0; c < total; c++) begin
      next_allow_in = (c == total - 1) ? 1'b1 : (c < first ? 1'($urandom) : 1'b0);
      @(negedge clk);
      check("mem_over", MEM_over, (c >= first));
      check("dm_wen", dm_wen, (c == 0) ? wen : 4'h0);
      if (c == 0) check("dm_addr", dm_addr, addr);
      if (c == 0 && st) check("dm_wdata", dm_wdata, wdata);
      if (c >= first) begin
        check("mem_wdata", MEM_wdata, res);
        check("wb_result", MEM_WB_bus[117:86], res);
      end
      if (c == total - 1) begin
        check("wb_fields", MEM_WB_bus[85:0], rest);
        check("mem_wen", MEM_wen, rest[37]);
        check("mem_wdest", MEM_wdest, rest[36:32]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic bubble(input logic [153:0] bus);
    EXE_MEM_bus_r = bus;
    MEM_valid     = 1'b0;
    next_allow_in = 1'($urandom);
    @(negedge clk);
    check("bub_over", MEM_over, 1'b0);
    check("bub_dm_wen", dm_wen, 4'h0);
    check("bub_mem_wen", MEM_wen, 1'b0);
    check("bub_mem_wdest", MEM_wdest, 5'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [85:0] rest7;
    int          kind;
    logic [31:0] addr;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);

    // Reset with a live store on the bus: nothing may leak out.
    reset         = 1'b1;
    MEM_valid     = 1'b1;
    next_allow_in = 1'b1;
    EXE_MEM_bus_r = make_bus(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h100, rand_rest());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dm_wen", dm_wen, 4'h0);
      check("rst_over", MEM_over, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bubble(make_bus(1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 32'h100, rand_rest()));

    // Directed cases.
    run_instr(1, 32'h100, 32'hDEADBEEF, 1'b0, 0, rand_rest());
    run_instr(2, 32'h103, 32'h000000A5, 1'b0, 0, rand_rest());
    run_instr(1, 32'h100, 32'h12F45678, 1'b0, 0, rand_rest());
    run_instr(4, 32'h102, 32'h0, 1'b1, 0, rand_rest());
    run_instr(4, 32'h102, 32'h0, 1'b0, 0, rand_rest());
    run_instr(2, 32'h105, 32'h0000003C, 1'b0, 3, rand_rest());
    rest7 = '0;
    rest7[37] = 1'b1;
    rest7[36:32] = 5'd7;
    run_instr(0, 32'h55, 32'h0, 1'b0, 0, rest7);
    bubble(make_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h55, rest7));

    // Reset during LOAD_WAIT abandons the load and clears the load register.
    EXE_MEM_bus_r = make_bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, rand_rest());
    MEM_valid     = 1'b1;
    next_allow_in = 1'b1;
    @(negedge clk);
    check("rlw_c0_over", MEM_over, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rlw_over", MEM_over, 1'b0);
    check("rlw_dm_wen", dm_wen, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    MEM_valid = 1'b0;
    @(negedge clk);
    check("rlw_after_over", MEM_over, 1'b0);
    check("rlw_after_dm_wen", dm_wen, 4'h0);
    check("rlw_load_data", MEM_wdata, 32'h0);
    @(posedge clk); #1;
    run_instr(1, 32'h108, 32'h89ABCDEF, 1'b0, 0, rand_rest());

    // Reset while DONE is holding completion.
    EXE_MEM_bus_r = make_bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h108, rand_rest());
    MEM_valid     = 1'b1;
    next_allow_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check("rdone_over", MEM_over, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    bubble(EXE_MEM_bus_r);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0)
        bubble(make_bus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        $urandom, {24'h000001, 8'($urandom)}, rand_rest()));
      kind = $urandom_range(0, 4);
      addr = (kind == 0) ? $urandom : {24'h000001, 8'($urandom)};
      run_instr(kind, addr, $urandom, 1'($urandom), $urandom_range(0, 2), rand_rest());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
